// File: rtl/nibble_serial_adder.sv
// ============================================================================
// nibble_serial_adder: W-bit add/subtract computed one nibble per cycle
// through a shared 4-bit ripple adder, with start/busy/done handshake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[4];
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  input  logic                   sub,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic                   overflow
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             accept;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [3:0]       nib_sum;
  logic             nib_co;
  logic             last;

  adder_4bit u_adder (
    .x  (a_q[{idx, 2'b00} +: 4]),
    .y  (b_q[{idx, 2'b00} +: 4]),
    .ci (carry),
    .s  (nib_sum),
    .co (nib_co)
  );

  assign last = (idx == LAST);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          accept   = 1'b1;
        end
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          state_nx = RUN;
          accept   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        // Subtraction is A + ~B + 1, so c_in has no effect in sub mode.
        a_q   <= a;
        b_q   <= sub ? ~b : b;
        carry <= sub ? 1'b1 : c_in;
        idx   <= '0;
      end else if (state == RUN) begin
        sum[{idx, 2'b00} +: 4] <= nib_sum;
        carry                  <= nib_co;
        idx                    <= idx + IDX_W'(1);
        if (last) begin
          c_out    <= nib_co;
          overflow <= a_q[W-1] ^ b_q[W-1] ^ nib_sum[3] ^ nib_co;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: vector table plus handshake corner sequences.
`default_nettype none

module tb_nibble_serial_adder;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, c_out, overflow;
  logic [W-1:0] sum;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .sub(sub), .busy(busy), .done(done), .sum(sum), .c_out(c_out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         ov;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         ov;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (busy && done) check("busy_and_done", 1, 0);
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("c_out", 32'(c_out), 32'(e.c));
        check("overflow", 32'(overflow), 32'(e.ov));
      end
    end
  end

  task automatic drive_start(input vec_t v, input bit expect_result);
    a = v.a; b = v.b; c_in = v.cin; sub = v.sub; start = 1'b1;
    if (expect_result) sb.push_back('{s: v.s, c: v.c, ov: v.ov});
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic wait_done(output int ncyc, output int nbusy);
    ncyc = 0; nbusy = 0;
    while (!done && ncyc < 30) begin
      if (busy) nbusy++;
      @(negedge clk);
      ncyc++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin : main
    vec_t vecs[10];
    vec_t v;
    int   ncyc, nbusy, d0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0};
    vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_c_out", 32'(c_out), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      drive_start(vecs[i], 1'b1);
      wait_done(ncyc, nbusy);
      check("busy_cycles", 32'(nbusy), NIBBLES);
      @(negedge clk);
      check("done_width", 32'(done), 0);
    end

    // Start pulse during RUN must be ignored.
    v = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
    d0 = done_cnt;
    drive_start(v, 1'b1);
    v = '{16'hAAAA, 16'h2222, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0};
    drive_start(v, 1'b0);
    repeat (12) @(negedge clk);
    check("busy_prot_dones", 32'(done_cnt - d0), 1);

    // Back-to-back: start held during DONE.
    v = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    drive_start(v, 1'b1);
    wait_done(ncyc, nbusy);
    v = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    drive_start(v, 1'b1);
    check("b2b_busy_rise", 32'(busy), 1);
    check("b2b_done_fall", 32'(done), 0);
    wait_done(ncyc, nbusy);
    check("b2b_spacing", 32'(ncyc + 1), NIBBLES + 1);
    @(negedge clk);

    // Leave c_out/overflow set, then reset during the 3rd RUN cycle.
    v = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    drive_start(v, 1'b1);
    wait_done(ncyc, nbusy);
    @(negedge clk);
    v = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    drive_start(v, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_sum", 32'(sum), 0);
    check("mid_rst_c_out", 32'(c_out), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt - d0), 0);
    v = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    drive_start(v, 1'b1);
    wait_done(ncyc, nbusy);
    check("post_rst_busy_cycles", 32'(nbusy), NIBBLES);
    repeat (2) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
